// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined decode/control unit.
// Field widths live here so the decoder, interface and stage registers agree.
package ctrl_pkg;

   localparam int OPC_W    = 6;
   localparam int FUNCT_W  = 6;
   localparam int REG_AW   = 5;
   localparam int ALU_OP_W = 2;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 6'b111111;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 2'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_LOAD = 2'd1;

   typedef struct packed {
      logic                valid;
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_src;
      logic                wr;
      logic                wbsrc;
      logic [REG_AW-1:0]   dest;
      logic                illegal;
   } ctrl_word_t;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// Instruction handshake between fetch (master) and the decode pipeline (slave).
interface ctrl_pipe_unit_if;
   import ctrl_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [OPC_W-1:0]   Opcode;
   logic [FUNCT_W-1:0] Funct;
   logic [REG_AW-1:0]  Rs;
   logic [REG_AW-1:0]  Rt;
   logic [REG_AW-1:0]  Rd;

   modport master (
      output in_valid, Opcode, Funct, Rs, Rt, Rd,
      input  in_ready
   );

   modport slave (
      input  in_valid, Opcode, Funct, Rs, Rt, Rd,
      output in_ready
   );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode/funct decode into a control word.
// Also reports whether Rt is a genuine source operand for hazard checking.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OPC_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [REG_AW-1:0]  rt,
   input  logic [REG_AW-1:0]  rd,
   output ctrl_word_t         word,
   output logic               rt_used
);

   logic unused_funct;
   assign unused_funct = ^funct[FUNCT_W-2:0];

   always_comb begin
      word         = '0;
      word.valid   = 1'b1;
      word.alu_op  = ALU_OP_LOAD;
      word.illegal = 1'b0;
      unique case (opcode)
         OPC_RTYPE: begin
            word.alu_op  = ALU_OP_ADD;
            word.alu_src = ~funct[FUNCT_W-1];
            word.wr      = 1'b1;
            word.wbsrc   = 1'b0;
            word.dest    = rd;
         end
         OPC_LOAD: begin
            word.alu_op  = ALU_OP_LOAD;
            word.alu_src = 1'b0;
            word.wr      = 1'b1;
            word.wbsrc   = 1'b1;
            word.dest    = rt;
         end
         default: begin
            word.illegal = 1'b1;
         end
      endcase
      // Register 0 is hardwired; writing it is a no-op and must not interlock.
      if (word.dest == '0) begin
         word.wr = 1'b0;
      end
   end

   // A load names its destination in Rt, and immediates replace Rt entirely.
   assign rt_used = ~word.alu_src & (opcode != OPC_LOAD);

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined decode/control: one instruction per cycle, DEPTH stages (EX..WB),
// RAW interlock against in-flight writers and a saturating stall counter.
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int DEPTH       = 2,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ctrl_pipe_unit_if.slave        fe,
   input  logic                   flush,
   output logic                   ex_valid,
   output logic [ALU_OP_W-1:0]    ALU_op,
   output logic                   ALU_src,
   output logic                   wb_valid,
   output logic                   Reg_write,
   output logic                   Writeback_src,
   output logic [REG_AW-1:0]      wb_rd,
   output logic                   illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   ctrl_word_t [DEPTH-1:0] stage_reg;
   ctrl_word_t [DEPTH-1:0] stage_next;
   ctrl_word_t             dec_word;
   logic                   dec_rt_used;
   logic [DEPTH-2:0]       hazard_hit;
   logic                   stall;
   logic                   accept;
   logic [STALL_CNT_W-1:0] stall_cnt_reg;
   logic [STALL_CNT_W-1:0] stall_cnt_next;

   ctrl_decode u_decode (
      .opcode  (fe.Opcode),
      .funct   (fe.Funct),
      .rt      (fe.Rt),
      .rd      (fe.Rd),
      .word    (dec_word),
      .rt_used (dec_rt_used)
   );

   // WB is excluded: the register file writes before it reads.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH-1; gi++) begin : g_hazard
         assign hazard_hit[gi] = stage_reg[gi].valid & stage_reg[gi].wr &
                                 (stage_reg[gi].dest != '0) &
                                 ((stage_reg[gi].dest == fe.Rs) |
                                  (dec_rt_used & (stage_reg[gi].dest == fe.Rt)));
      end
   endgenerate

   assign stall       = fe.in_valid & (|hazard_hit);
   assign fe.in_ready = ~stall & ~flush;
   assign accept      = fe.in_valid & fe.in_ready;

   // Stage 0 never needs a flush term: accept is already false during flush.
   assign stage_next[0] = accept ? dec_word : '0;

   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_stage
         assign stage_next[gi] = flush ? '0 : stage_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= stage_next;
      end
   end

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (stall && !flush && !(&stall_cnt_reg)) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign ex_valid      = stage_reg[0].valid;
   assign ALU_op        = ex_valid ? stage_reg[0].alu_op  : '0;
   assign ALU_src       = ex_valid & stage_reg[0].alu_src;
   assign illegal       = ex_valid & stage_reg[0].illegal;

   assign wb_valid      = stage_reg[DEPTH-1].valid;
   assign Reg_write     = wb_valid & stage_reg[DEPTH-1].wr;
   assign Writeback_src = wb_valid & stage_reg[DEPTH-1].wbsrc;
   assign wb_rd         = wb_valid ? stage_reg[DEPTH-1].dest : '0;
   assign stall_cnt     = stall_cnt_reg;

   // ALU fields have no consumer once the word reaches writeback.
   logic unused_wb;
   assign unused_wb = ^{stage_reg[DEPTH-1].alu_op, stage_reg[DEPTH-1].alu_src,
                        stage_reg[DEPTH-1].illegal};

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit; a second narrow-counter instance covers saturation.
module tb_ctrl_pipe_unit;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_n_sat;
   logic flush;
   logic flush_sat;

   always #5 clk = ~clk;

   ctrl_pipe_unit_if fe ();
   ctrl_pipe_unit_if fe_sat ();

   logic                ex_valid, ALU_src, wb_valid, Reg_write, Writeback_src, illegal;
   logic [ALU_OP_W-1:0] ALU_op;
   logic [REG_AW-1:0]   wb_rd;
   logic [15:0]         stall_cnt;

   logic                s_ex_valid, s_ALU_src, s_wb_valid, s_Reg_write, s_Writeback_src, s_illegal;
   logic [ALU_OP_W-1:0] s_ALU_op;
   logic [REG_AW-1:0]   s_wb_rd;
   logic [7:0]          s_stall_cnt;

   ctrl_pipe_unit #(.DEPTH(2), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .fe(fe.slave), .flush(flush),
      .ex_valid(ex_valid), .ALU_op(ALU_op), .ALU_src(ALU_src),
      .wb_valid(wb_valid), .Reg_write(Reg_write), .Writeback_src(Writeback_src),
      .wb_rd(wb_rd), .illegal(illegal), .stall_cnt(stall_cnt)
   );

   ctrl_pipe_unit #(.DEPTH(2), .STALL_CNT_W(8)) dut_sat (
      .clk(clk), .rst_n(rst_n_sat), .fe(fe_sat.slave), .flush(flush_sat),
      .ex_valid(s_ex_valid), .ALU_op(s_ALU_op), .ALU_src(s_ALU_src),
      .wb_valid(s_wb_valid), .Reg_write(s_Reg_write), .Writeback_src(s_Writeback_src),
      .wb_rd(s_wb_rd), .illegal(s_illegal), .stall_cnt(s_stall_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vec++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      fe.in_valid = v;
      fe.Opcode   = opc;
      fe.Funct    = fn;
      fe.Rs       = rs;
      fe.Rt       = rt;
      fe.Rd       = rd;
   endtask

   initial begin
      rst_n = 1'b0;
      rst_n_sat = 1'b0;
      flush = 1'b0;
      flush_sat = 1'b0;
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      // Constant self-dependent R-type: stalls on every other cycle.
      fe_sat.in_valid = 1'b1;
      fe_sat.Opcode   = 6'h00;
      fe_sat.Funct    = 6'b100000;
      fe_sat.Rs       = 5'd1;
      fe_sat.Rt       = 5'd2;
      fe_sat.Rd       = 5'd1;

      // Reset state
      #2;
      check("rst_ex_valid", ex_valid, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_reg_write", Reg_write, 0);
      check("rst_alu_op", ALU_op, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_in_ready", fe.in_ready, 1);
      tick();
      tick();
      rst_n = 1'b1;

      // Basic R-type through the pipe
      issue(1'b1, 6'h00, 6'b100000, 5'd1, 5'd2, 5'd3);
      #1;
      check("rt_in_ready", fe.in_ready, 1);
      tick();
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      check("rt_ex_valid", ex_valid, 1);
      check("rt_alu_src", ALU_src, 0);
      check("rt_alu_op", ALU_op, 0);
      check("rt_illegal", illegal, 0);
      check("rt_wb_early", wb_valid, 0);
      tick();
      check("rt_wb_valid", wb_valid, 1);
      check("rt_reg_write", Reg_write, 1);
      check("rt_wb_rd", wb_rd, 3);
      check("rt_wbsrc", Writeback_src, 0);
      check("rt_ex_drained", ex_valid, 0);
      tick();
      check("rt_wb_drained", wb_valid, 0);

      // Load followed by dependent R-type: one stall cycle
      issue(1'b1, 6'h3F, 6'h00, 5'd1, 5'd5, 5'd0);
      tick();
      check("ld_ex_valid", ex_valid, 1);
      check("ld_alu_op", ALU_op, 1);
      issue(1'b1, 6'h00, 6'b100000, 5'd5, 5'd6, 5'd7);
      #1;
      check("ld_stall_ready", fe.in_ready, 0);
      tick();
      check("ld_stall_cnt", stall_cnt, 1);
      check("ld_bubble", ex_valid, 0);
      check("ld_wb_valid", wb_valid, 1);
      check("ld_wb_rd", wb_rd, 5);
      check("ld_wbsrc", Writeback_src, 1);
      check("ld_reg_write", Reg_write, 1);
      check("ld_ready_again", fe.in_ready, 1);
      tick();
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      check("dep_ex_valid", ex_valid, 1);
      check("dep_wb_gap", wb_valid, 0);
      tick();
      check("dep_wb_valid", wb_valid, 1);
      check("dep_wb_rd", wb_rd, 7);
      check("dep_stall_cnt", stall_cnt, 1);

      // Immediate R-type does not read Rt; register form does
      issue(1'b1, 6'h00, 6'b100000, 5'd1, 5'd2, 5'd9);
      tick();
      issue(1'b1, 6'h00, 6'b000000, 5'd1, 5'd9, 5'd10);
      #1;
      check("imm_no_stall", fe.in_ready, 1);
      tick();
      check("imm_ex_valid", ex_valid, 1);
      check("imm_alu_src", ALU_src, 1);
      issue(1'b1, 6'h00, 6'b100000, 5'd1, 5'd10, 5'd11);
      #1;
      check("rtsrc_stall", fe.in_ready, 0);
      tick();
      check("rtsrc_stall_cnt", stall_cnt, 2);
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      tick();
      tick();

      // Illegal opcode
      issue(1'b1, 6'h12, 6'b100000, 5'd0, 5'd0, 5'd4);
      tick();
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      check("ill_ex_valid", ex_valid, 1);
      check("ill_flag", illegal, 1);
      check("ill_alu_op", ALU_op, 1);
      tick();
      check("ill_wb_valid", wb_valid, 1);
      check("ill_reg_write", Reg_write, 0);
      tick();

      // Destination register 0 never writes and never interlocks
      issue(1'b1, 6'h00, 6'b100000, 5'd1, 5'd2, 5'd0);
      tick();
      issue(1'b1, 6'h00, 6'b100000, 5'd0, 5'd0, 5'd8);
      #1;
      check("rd0_no_stall", fe.in_ready, 1);
      tick();
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      check("rd0_wb_valid", wb_valid, 1);
      check("rd0_reg_write", Reg_write, 0);
      check("rd0_next_ex", ex_valid, 1);
      tick();
      tick();
      check("rd0_stall_cnt", stall_cnt, 2);

      // Flush kills everything in flight and overrides a stall
      issue(1'b1, 6'h00, 6'b100000, 5'd1, 5'd2, 5'd12);
      tick();
      issue(1'b1, 6'h00, 6'b100000, 5'd12, 5'd2, 5'd13);
      flush = 1'b1;
      #1;
      check("fl_in_ready", fe.in_ready, 0);
      tick();
      flush = 1'b0;
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      check("fl_ex_valid", ex_valid, 0);
      check("fl_wb_valid", wb_valid, 0);
      check("fl_reg_write", Reg_write, 0);
      check("fl_stall_cnt", stall_cnt, 2);
      tick();
      check("fl_wb_after", wb_valid, 0);
      check("fl_reg_write_after", Reg_write, 0);

      // Asynchronous reset mid-stream
      issue(1'b1, 6'h3F, 6'h00, 5'd1, 5'd5, 5'd0);
      tick();
      issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ex_valid", ex_valid, 0);
      check("ar_alu_op", ALU_op, 0);
      check("ar_wb_valid", wb_valid, 0);
      check("ar_reg_write", Reg_write, 0);
      check("ar_stall_cnt", stall_cnt, 0);
      #2;
      rst_n = 1'b1;
      tick();
      check("ar_no_wb_escape", wb_valid, 0);
      check("ar_no_write", Reg_write, 0);

      // Saturation on the narrow-counter instance
      rst_n_sat = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("sat_count_10", s_stall_cnt, 10);
      for (int i = 0; i < 580; i++) tick();
      check("sat_hold_ff", s_stall_cnt, 8'hFF);
      rst_n_sat = 1'b0;
      #1;
      check("sat_reset", s_stall_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Pipelined successor to the combinational decode/control block.
- Accepts one instruction per cycle over a valid/ready handshake and decodes Opcode/Funct into a control word plus register addresses.
- Carries that word through DEPTH registered stages (EX … WB).
- Interlocks the front end on read-after-write hazards against in-flight writers (no forwarding) and counts stall cycles.
- Sits between instruction fetch and the datapath ALU/register file.

Parameters:
OPC_W, 6, opcode width
FUNCT_W, 6, funct width; Funct[FUNCT_W-1] selects register vs immediate ALU source
REG_AW, 5, register address width
ALU_OP_W, 2, ALU_op width (codes zero-extended)
DEPTH, 2, stages after decode, min 2; stage 0 = EX, stage DEPTH-1 = WB
OPC_RTYPE, 6'b000000, R-type opcode
OPC_LOAD, 6'b111111, load-class opcode
STALL_CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present
in_ready  out  1  decode can accept this cycle
Opcode  in  OPC_W  instruction opcode
Funct  in  FUNCT_W  instruction funct
Rs  in  REG_AW  source 1
Rt  in  REG_AW  source 2 / load destination
Rd  in  REG_AW  R-type destination
flush  in  1  synchronous pipeline kill
ex_valid  out  1  stage 0 holds a real instruction
ALU_op  out  ALU_OP_W  stage 0 ALU operation
ALU_src  out  1  stage 0: 1 = immediate, 0 = register
wb_valid  out  1  stage DEPTH-1 valid
Reg_write  out  1  stage DEPTH-1 write enable (already qualified by wb_valid)
Writeback_src  out  1  stage DEPTH-1: 0 = ALU, 1 = memory
wb_rd  out  REG_AW  stage DEPTH-1 destination
illegal  out  1  stage 0 holds an undecodable opcode
stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0. ALU_op, ALU_src, Reg_write, Writeback_src, wb_rd, illegal all 0. stall_cnt = 0. in_ready follows its combinational equation; it is 1 once out of reset with no hazard and no flush.
- Decode (combinational, registered into stage 0):
  - OPC_RTYPE: ALU_op = 0, ALU_src = ~Funct[MSB], wr = 1, wbsrc = 0, dest = Rd.
  - OPC_LOAD: ALU_op = 1, ALU_src = 0, wr = 1, wbsrc = 1, dest = Rt.
  - Any other opcode: ALU_op = 1, ALU_src = 0, wr = 0, wbsrc = 0, illegal = 1.
  - dest == 0 forces wr = 0.
- Uses: Rs is always read. Rt is read only when the decoded ALU_src = 0 and the opcode is not OPC_LOAD.
- Hazard: stall = in_valid & any stage k in 0..DEPTH-2 with valid & wr & dest == a used source (nonzero).
  - The WB stage never causes a stall: the register file is write-before-read.
- in_ready = ~stall & ~flush.
- Accept when in_valid & in_ready: stage 0 loads the decoded word next edge. Otherwise stage 0 loads a bubble (valid = 0, controls 0).
- The pipeline advances every cycle unconditionally. Stage k+1 ← stage k. There is no downstream backpressure.
- Outputs: stage-0 outputs are gated to 0 when ex_valid = 0. Reg_write = stage[DEPTH-1].wr & valid.
- Latency: instruction accepted at edge n → ex_valid at n+1 → wb_valid at n+DEPTH.
- flush = 1: every valid bit clears at the next edge, in_ready = 0 that cycle, nothing is accepted. flush overrides stall. stall_cnt does not increment on a flush cycle.
- stall_cnt increments on each cycle with stall & ~flush and saturates at all-ones (no wrap).
- Reset asserted mid-operation clears all state immediately. No partial writeback escapes after reset deasserts.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants OPC_RTYPE and OPC_LOAD
  - ALU_op code constants ALU_OP_ADD = 0, ALU_OP_LOAD = 1
  - packed typedef ctrl_word_t {valid, alu_op, alu_src, wr, wbsrc, dest, illegal}
- Sub-module ctrl_decode: the purely combinational opcode/funct → ctrl_word_t decode, reusable by other pipelines.
- The stage registers and hazard compare stay in the top module, generated over DEPTH.

Test Plan:
- Reset, then R-type Opcode=0, Funct=6'b100000, Rd=3 → ex_valid at +1 with ALU_src=0, ALU_op=0; wb_valid at +2 with Reg_write=1, wb_rd=3, Writeback_src=0.
- Load Opcode=6'h3F, Rt=5, then R-type reading Rs=5 → in_ready=0 for exactly 1 cycle (DEPTH=2), stall_cnt=1, second instruction reaches WB at cycle 4.
- R-type with Funct[5]=0 (immediate) and Rt matching an in-flight dest → no stall, ALU_src=1.
- Opcode=6'h12 → illegal=1 in EX, Reg_write=0 in WB. Any Rd=0 instruction → Reg_write=0 and never causes a stall.
- Three back-to-back instructions, then flush in cycle 2 → all valids 0 next cycle, in_ready=0 during flush, no Reg_write observed.
- Force a continuous hazard for 2^16+5 cycles → stall_cnt holds 16'hFFFF. Assert rst_n=0 mid-stream → all outputs 0 asynchronously, stall_cnt=0.
